lane_hit_judge: RTL and testbench

//  Downstream consumer of the per-lane falling-block generators (block_h buses).
//  Per lane, watches block height and player key; grades each block PERFECT/GOOD/MISS.

---
 rtl/lane_hit_judge_pkg.sv | 46 ++++
 rtl/lane_hit_judge_if.sv | 37 +++
 rtl/lane_hit_judge_fsm.sv | 94 +++++++++
 rtl/lane_hit_judge.sv | 148 ++++++++++++++
 tb/tb_lane_hit_judge.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lane_hit_judge_pkg.sv
// -----------------------------------------------------------------------------
// lane_judge_pkg
//   Shared types and default constants for the lane hit judge.
//   - judge_code_t : judgment codes reported on judge_code
//   - lane_state_t : per-lane tracker state
//   - default window / scoring constants
//   - popcount32   : helper used to count simultaneous per-lane strobes
// -----------------------------------------------------------------------------
package lane_judge_pkg;

   localparam int LANES_DEF    = 4;
   localparam int H_W_DEF      = 10;
   localparam int H_IDLE_DEF   = 720;
   localparam int HIT_LO_DEF   = 600;
   localparam int HIT_HI_DEF   = 680;
   localparam int PERF_LO_DEF  = 630;
   localparam int PERF_HI_DEF  = 650;
   localparam int PTS_PERF_DEF = 3;
   localparam int PTS_GOOD_DEF = 1;
   localparam int SCORE_W_DEF  = 16;
   localparam int CNT_W_DEF    = 8;

   typedef enum logic [1:0] {
      J_NONE = 2'b00,
      J_GOOD = 2'b01,
      J_PERF = 2'b10,
      J_MISS = 2'b11
   } judge_code_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FALL = 2'd1,
      DONE = 2'd2
   } lane_state_t;

   // Number of set bits; callers zero-extend lane vectors to 32 bits.
   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int b = 0; b < 32; b++) begin
         n = n + {5'd0, v[b]};
      end
      return n;
   endfunction

endpackage

// File: rtl/lane_hit_judge_if.sv
// -----------------------------------------------------------------------------
// lane_hit_judge_if
//   Bus between the block generators / key inputs and the judge.
//   master : drives restart, stop_or_endgame, block_h, key; reads results
//   slave  : the judge; reads the inputs and drives judge_* and counters
//   block_h packs lane i at [i*H_W +: H_W].
// -----------------------------------------------------------------------------
interface lane_hit_judge_if #(
   parameter int LANES   = 4,
   parameter int H_W     = 10,
   parameter int SCORE_W = 16,
   parameter int CNT_W   = 8,
   parameter int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
);
   logic                   restart;
   logic                   stop_or_endgame;
   logic [LANES*H_W-1:0]   block_h;
   logic [LANES-1:0]       key;

   logic                   judge_valid;
   logic [LANE_W-1:0]      judge_lane;
   logic [1:0]             judge_code;
   logic [SCORE_W-1:0]     score;
   logic [CNT_W-1:0]       combo;
   logic [CNT_W-1:0]       max_combo;
   logic [CNT_W-1:0]       miss_cnt;

   modport master (
      output restart, stop_or_endgame, block_h, key,
      input  judge_valid, judge_lane, judge_code, score, combo, max_combo, miss_cnt
   );

   modport slave (
      input  restart, stop_or_endgame, block_h, key,
      output judge_valid, judge_lane, judge_code, score, combo, max_combo, miss_cnt
   );
endinterface

// File: rtl/lane_hit_judge_fsm.sv
// -----------------------------------------------------------------------------
// lane_judge_fsm
//   Tracks one lane's falling block and grades it.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clr_i        synchronous clear (same effect as reset)
//     freeze_i     hold state and previous height, suppress strobes
//     h_i          current block height for this lane
//     key_i        current key level; key_q_i is last cycle's level
//     good_o, perf_o, miss_o   one-cycle judgment strobes (combinational)
// -----------------------------------------------------------------------------
module lane_judge_fsm
   import lane_judge_pkg::*;
#(
   parameter int H_W     = H_W_DEF,
   parameter int H_IDLE  = H_IDLE_DEF,
   parameter int HIT_LO  = HIT_LO_DEF,
   parameter int HIT_HI  = HIT_HI_DEF,
   parameter int PERF_LO = PERF_LO_DEF,
   parameter int PERF_HI = PERF_HI_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr_i,
   input  logic           freeze_i,
   input  logic [H_W-1:0] h_i,
   input  logic           key_i,
   input  logic           key_q_i,
   output logic           good_o,
   output logic           perf_o,
   output logic           miss_o
);

   localparam logic [H_W-1:0] IDLE_H  = H_W'(H_IDLE);
   localparam logic [H_W-1:0] HLO_H   = H_W'(HIT_LO);
   localparam logic [H_W-1:0] HHI_H   = H_W'(HIT_HI);
   localparam logic [H_W-1:0] PLO_H   = H_W'(PERF_LO);
   localparam logic [H_W-1:0] PHI_H   = H_W'(PERF_HI);

   lane_state_t    state_q, state_d;
   logic [H_W-1:0] prev_h_q;

   logic rise, respawn, in_hit, in_perf, past_hit;

   assign rise     = key_i & ~key_q_i;
   // Height only ever grows while a block falls, so a drop means a new block.
   assign respawn  = h_i < prev_h_q;
   assign in_hit   = (h_i >= HLO_H) && (h_i <= HHI_H);
   assign in_perf  = (h_i >= PLO_H) && (h_i <= PHI_H);
   assign past_hit = h_i > HHI_H;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         state_q  <= IDLE;
         prev_h_q <= IDLE_H;
      end else if (!freeze_i) begin
         state_q  <= state_d;
         prev_h_q <= h_i;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (h_i < IDLE_H) state_d = FALL;
         FALL: begin
            if (respawn)              state_d = FALL;
            else if (rise && in_hit)  state_d = DONE;
            else if (past_hit)        state_d = DONE;
         end
         DONE: begin
            if (respawn)              state_d = FALL;
            else if (h_i == IDLE_H)   state_d = IDLE;
         end
         default:                     state_d = IDLE;
      endcase
   end

   // Output logic: judgments only come out of FALL, in priority order.
   always_comb begin
      good_o = 1'b0;
      perf_o = 1'b0;
      miss_o = 1'b0;
      if (!freeze_i && state_q == FALL) begin
         if (respawn)                miss_o = 1'b1;
         else if (rise && in_perf)   perf_o = 1'b1;
         else if (rise && in_hit)    good_o = 1'b1;
         else if (past_hit)          miss_o = 1'b1;
      end
   end

endmodule

// File: rtl/lane_hit_judge.sv
// -----------------------------------------------------------------------------
// lane_hit_judge (top)
//   Grades falling blocks against player keys on every lane and keeps score.
//   Ports:
//     clk    block-tick clock (same as the block generators)
//     rst_n  synchronous active-low reset
//     bus    lane_hit_judge_if.slave:
//              in : restart, stop_or_endgame, block_h, key
//              out: judge_valid/lane/code (registered, one cycle after the
//                   sampled height/edge), score, combo, max_combo, miss_cnt
// -----------------------------------------------------------------------------
module lane_hit_judge
   import lane_judge_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int H_W      = H_W_DEF,
   parameter int H_IDLE   = H_IDLE_DEF,
   parameter int HIT_LO   = HIT_LO_DEF,
   parameter int HIT_HI   = HIT_HI_DEF,
   parameter int PERF_LO  = PERF_LO_DEF,
   parameter int PERF_HI  = PERF_HI_DEF,
   parameter int PTS_PERF = PTS_PERF_DEF,
   parameter int PTS_GOOD = PTS_GOOD_DEF,
   parameter int SCORE_W  = SCORE_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   lane_hit_judge_if.slave bus
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic             clr;
   logic [LANES-1:0] key_q;
   logic [LANES-1:0] good, perf, miss;

   assign clr = bus.restart;

   // Key history keeps tracking while frozen so that a key already held when
   // the freeze ends does not look like a fresh press.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) key_q <= '0;
      else               key_q <= bus.key;
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      lane_judge_fsm #(
         .H_W     (H_W),
         .H_IDLE  (H_IDLE),
         .HIT_LO  (HIT_LO),
         .HIT_HI  (HIT_HI),
         .PERF_LO (PERF_LO),
         .PERF_HI (PERF_HI)
      ) u_fsm (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr_i    (clr),
         .freeze_i (bus.stop_or_endgame),
         .h_i      (bus.block_h[gi*H_W +: H_W]),
         .key_i    (bus.key[gi]),
         .key_q_i  (key_q[gi]),
         .good_o   (good[gi]),
         .perf_o   (perf[gi]),
         .miss_o   (miss[gi])
      );
   end

   // Accumulators
   logic               valid_q, valid_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [1:0]         code_q, code_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [CNT_W-1:0]   combo_q, combo_d;
   logic [CNT_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0]   miss_q, miss_d;

   logic [CNT_W-1:0]   n_good, n_perf, n_hit, n_miss;
   logic [SCORE_W:0]   pts, score_sum;
   logic [CNT_W:0]     combo_sum, miss_sum;

   always_comb begin
      n_good = CNT_W'(popcount32(32'(good)));
      n_perf = CNT_W'(popcount32(32'(perf)));
      n_miss = CNT_W'(popcount32(32'(miss)));
      n_hit  = n_good + n_perf;

      pts = ((SCORE_W+1)'(n_perf) * (SCORE_W+1)'(PTS_PERF))
          + ((SCORE_W+1)'(n_good) * (SCORE_W+1)'(PTS_GOOD));

      // Saturating adds: the carry-out bit selects all-ones.
      score_sum = {1'b0, score_q} + pts;
      score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

      combo_sum = {1'b0, combo_q} + {1'b0, n_hit};
      if (n_miss != '0)          combo_d = '0;
      else if (combo_sum[CNT_W]) combo_d = '1;
      else                       combo_d = combo_sum[CNT_W-1:0];

      max_d = (combo_d > max_q) ? combo_d : max_q;

      miss_sum = {1'b0, miss_q} + {1'b0, n_miss};
      miss_d   = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];

      // Report the lowest-index judged lane: scan high to low, last write wins.
      valid_d = 1'b0;
      lane_d  = '0;
      code_d  = J_NONE;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (good[i] || perf[i] || miss[i]) begin
            valid_d = 1'b1;
            lane_d  = LANE_W'(i);
            code_d  = miss[i] ? J_MISS : (perf[i] ? J_PERF : J_GOOD);
         end
      end
   end

   // While frozen the lane strobes are all zero, so every counter's next value
   // equals its current value and judge_valid drops without extra gating.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         valid_q <= 1'b0;
         lane_q  <= '0;
         code_q  <= J_NONE;
         score_q <= '0;
         combo_q <= '0;
         max_q   <= '0;
         miss_q  <= '0;
      end else begin
         valid_q <= valid_d;
         lane_q  <= lane_d;
         code_q  <= code_d;
         score_q <= score_d;
         combo_q <= combo_d;
         max_q   <= max_d;
         miss_q  <= miss_d;
      end
   end

   assign bus.judge_valid = valid_q;
   assign bus.judge_lane  = lane_q;
   assign bus.judge_code  = code_q;
   assign bus.score       = score_q;
   assign bus.combo       = combo_q;
   assign bus.max_combo   = max_q;
   assign bus.miss_cnt    = miss_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// -----------------------------------------------------------------------------
// tb_lane_hit_judge
//   Directed stimulus for lane_hit_judge. Each step states the judgment every
//   lane should produce; the step derives the expected outputs from that,
//   pushes them to a scoreboard, clocks the DUT and compares one cycle later.
// -----------------------------------------------------------------------------
module tb_lane_hit_judge;
   import lane_judge_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   lane_hit_judge_if bus ();

   lane_hit_judge dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        v;
      logic [1:0]  lane;
      logic [1:0]  code;
      logic [15:0] score;
      logic [7:0]  combo;
      logic [7:0]  maxc;
      logic [7:0]  miss;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [9:0]  h [4];
   logic [3:0]  k;
   logic        stop, rs;
   logic [15:0] e_score;
   logic [7:0]  e_combo, e_max, e_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [1:0] c0, input logic [1:0] c1,
                       input logic [1:0] c2, input logic [1:0] c3);
      exp_t       e;
      exp_t       got;
      logic [1:0] c [4];
      int         hits, misses, pts, s;
      c = '{c0, c1, c2, c3};
      bus.block_h         = {h[3], h[2], h[1], h[0]};
      bus.key             = k;
      bus.stop_or_endgame = stop;
      bus.restart         = rs;

      e = '0;
      if (!rst_n || rs) begin
         e_score = '0; e_combo = '0; e_max = '0; e_miss = '0;
      end else begin
         hits = 0; misses = 0; pts = 0;
         for (int i = 0; i < 4; i++) begin
            if (c[i] == J_GOOD) begin hits++; pts += 1; end
            if (c[i] == J_PERF) begin hits++; pts += 3; end
            if (c[i] == J_MISS) misses++;
         end
         for (int i = 3; i >= 0; i--) begin
            if (c[i] != J_NONE) begin
               e.v    = 1'b1;
               e.lane = i[1:0];
               e.code = c[i];
            end
         end
         s = int'(e_score) + pts;
         e_score = (s > 65535) ? 16'hFFFF : s[15:0];
         if (misses > 0) e_combo = '0;
         else begin
            s = int'(e_combo) + hits;
            e_combo = (s > 255) ? 8'hFF : s[7:0];
         end
         if (e_combo > e_max) e_max = e_combo;
         s = int'(e_miss) + misses;
         e_miss = (s > 255) ? 8'hFF : s[7:0];
      end
      e.score = e_score; e.combo = e_combo; e.maxc = e_max; e.miss = e_miss;
      sb.push_back(e);

      @(posedge clk);
      #1;
      got.v = 1'b0;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".valid"},     32'(bus.judge_valid), 32'(e.v));
         chk({tag, ".lane"},      32'(bus.judge_lane),  32'(e.lane));
         chk({tag, ".code"},      32'(bus.judge_code),  32'(e.code));
         chk({tag, ".score"},     32'(bus.score),       32'(e.score));
         chk({tag, ".combo"},     32'(bus.combo),       32'(e.combo));
         chk({tag, ".max_combo"}, 32'(bus.max_combo),   32'(e.maxc));
         chk({tag, ".miss_cnt"},  32'(bus.miss_cnt),    32'(e.miss));
      end
      $display("step %-12s h=%0d/%0d/%0d/%0d key=%b stop=%b rs=%b -> v=%0d lane=%0d code=%b score=%0d combo=%0d max=%0d miss=%0d",
               tag, h[0], h[1], h[2], h[3], k, stop, rs, bus.judge_valid, bus.judge_lane,
               bus.judge_code, bus.score, bus.combo, bus.max_combo, bus.miss_cnt);
   endtask

   initial begin
      rst_n = 1'b0; rs = 1'b0; stop = 1'b0; k = 4'b0000;
      for (int i = 0; i < 4; i++) h[i] = 10'd720;
      e_score = '0; e_combo = '0; e_max = '0; e_miss = '0;

      step("reset0", J_NONE, J_NONE, J_NONE, J_NONE);
      step("reset1", J_NONE, J_NONE, J_NONE, J_NONE);
      rst_n = 1'b1;

      // Lane 0 ramps from 120; press at 640 is PERFECT.
      for (int hh = 120; hh <= 620; hh += 50) begin
         h[0] = 10'(hh);
         step("ramp", J_NONE, J_NONE, J_NONE, J_NONE);
      end
      h[0] = 10'd640; k = 4'b0001; step("perf640", J_PERF, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd660;              step("done_hold", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd700; k = 4'b0000; step("done_rel", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720;              step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Press at 610 is GOOD.
      h[0] = 10'd120;              step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd400;              step("fall", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd610; k = 4'b0001; step("good610", J_GOOD, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720; k = 4'b0000; step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Early press ignored; held key is no edge; MISS once past the window.
      h[0] = 10'd120;              step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd500; k = 4'b0001; step("early500", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd600;              step("held600", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd681;              step("miss681", J_MISS, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd700; k = 4'b0000; step("done", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd120;              step("respawn", J_NONE, J_NONE, J_NONE, J_NONE);

      // No key: 680 is still in the window, 681 misses.
      h[0] = 10'd400;              step("fall", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd680;              step("edge680", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd681;              step("nokey681", J_MISS, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720;              step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Respawn while falling misses the old block and keeps tracking.
      h[0] = 10'd120;              step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd300;              step("fall", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd120;              step("fall_resp", J_MISS, J_NONE, J_NONE, J_NONE);

      // Lane 0 hit and lane 2 miss in the same cycle.
      h[0] = 10'd300; h[2] = 10'd120;              step("spawn2", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd645; h[2] = 10'd690; k = 4'b0001; step("hit0miss2", J_PERF, J_NONE, J_MISS, J_NONE);
      h[0] = 10'd720; h[2] = 10'd720; k = 4'b0000; step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Lanes 1 and 3 hit together: lowest lane reported, combo +2.
      h[1] = 10'd120; h[3] = 10'd120;              step("spawn13", J_NONE, J_NONE, J_NONE, J_NONE);
      h[1] = 10'd620; h[3] = 10'd640; k = 4'b1010; step("hit1hit3", J_NONE, J_GOOD, J_NONE, J_PERF);
      h[1] = 10'd720; h[3] = 10'd720; k = 4'b0000; step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Freeze: a press while frozen is lost, and no edge appears on release.
      h[0] = 10'd120;                          step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd640; k = 4'b0001; stop = 1'b1; step("frz_press", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd690;                          step("frz_past", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd645; stop = 1'b0;             step("unfrz_held", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd681;                          step("miss681", J_MISS, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720; k = 4'b0000;             step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Combo saturation: 64 rounds of four PERFECTs, then one more hit.
      for (int r = 0; r < 64; r++) begin
         for (int i = 0; i < 4; i++) h[i] = 10'd120;
         step("sat_spawn", J_NONE, J_NONE, J_NONE, J_NONE);
         for (int i = 0; i < 4; i++) h[i] = 10'd640;
         k = 4'b1111;
         step("sat_hit4", J_PERF, J_PERF, J_PERF, J_PERF);
         for (int i = 0; i < 4; i++) h[i] = 10'd720;
         k = 4'b0000;
         step("sat_idle", J_NONE, J_NONE, J_NONE, J_NONE);
      end
      h[0] = 10'd120;              step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd640; k = 4'b0001; step("sat_plus1", J_PERF, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720; k = 4'b0000; step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      // Restart during a judgment clears everything, no pulse.
      h[0] = 10'd120;                        step("spawn", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd640; k = 4'b0001; rs = 1'b1; step("restart", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd645; rs = 1'b0;             step("post_rs", J_NONE, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd681;                        step("rs_miss", J_MISS, J_NONE, J_NONE, J_NONE);
      h[0] = 10'd720; k = 4'b0000;           step("to_idle", J_NONE, J_NONE, J_NONE, J_NONE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
